multiport_regfile: RTL and testbench
====================================

// Module: multiport_regfile
// PURPOSE
//  Parametrised integer register file for the RV32E/RV32I cores: NUM_WR write ports, NUM_RD read ports.
//  x0 hardwired to zero; deterministic same-address write priority; hardware clear of all registers after reset.
//  Sits between decode (reads) and writeback/retire (writes); replaces the fixed two-write/two-read regfile.
// PARAMETERS
//  EMBEDDED  1   1: 16 registers (AW=4, RV32E); 0: 32 registers (AW=5, RV32I)
//  XLEN      32  register width in bits
//  NUM_WR    2   write ports, >=1
//  NUM_RD    2   read ports, >=1
//  (derived) AW = EMBEDDED ? 4 : 5; DEPTH = 2**AW
// PORTS
//  clk          in   1            clock, all state updates on rising edge
//  rst          in   1            synchronous reset, active-high
//  ready        out  1            1 = clear sequence finished, writes accepted
//  wr_en        in   NUM_WR       per-port write enable
//  wr_addr      in   NUM_WR*AW    port p address at [p*AW +: AW]
//  wr_data      in   NUM_WR*XLEN  port p data at [p*XLEN +: XLEN]
//  rd_addr      in   NUM_RD*AW    read port r address at [r*AW +: AW]
//  rd_data      out  NUM_RD*XLEN  read port r data, combinational from rd_addr
//  wr_conflict  out  1            registered pulse: >=2 enabled ports hit the same non-zero address last cycle
// BEHAVIOUR
//  Reset/state: FSM {CLEAR, RUN}. rst=1 (any cycle, incl. mid-clear or in RUN): state<=CLEAR, clr_idx<=1,
//   ready<=0, wr_conflict<=0. Register contents not touched by rst itself.
//  CLEAR: each clk with rst=0 writes 0 to Registers[clr_idx], clr_idx++; after writing DEPTH-1, state<=RUN,
//   ready<=1. ready rises DEPTH-1 clocks after rst deasserts (15 for EMBEDDED=1, 31 for EMBEDDED=0).
//  In CLEAR: wr_en ignored (writes dropped, no conflict flagged); all rd_data return 0.
//  RUN: for each register a, enabled ports with wr_addr==a are candidates; highest-index port wins, written at clk.
//  Writes to address 0 are discarded; rd_addr==0 always returns 0; address 0 never flags conflict.
//  Read latency: rd_data is combinational from storage; a write is visible on reads the cycle after its clk edge.
//  Reads of the same address on several read ports are independent and identical.
//  wr_conflict: set to 1 at clk if, that cycle in RUN, two or more enabled ports share a non-zero address;
//   otherwise 0. One-cycle pulse per conflicting cycle; does not alter the write result (priority still applies).
//  No X propagation: every output defined from first rst cycle; rd_data 0 until ready.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: in RUN, if rd_addr[r]!=0 matches an enabled wr_addr this cycle, rd_data[r]
//   returns the winning port's wr_data in the same cycle (write-to-read forwarding, priority as above).
//  REGFILE_BYPASS_EN undefined: no forwarding; rd_data[r] returns stored value, new data visible next cycle.
//  Bypass never applies in CLEAR or for address 0.
// TESTING
//  1 Reset/clear: fill regs via writes, pulse rst 1 cycle -> ready=0 for 15 clks (EMBEDDED=1), then 1;
//    every rd_data reads 0; wr_en during clear leaves regs 0.
//  2 Reset mid-clear: assert rst at clear cycle 7 -> clr_idx restarts, ready rises 15 clks after rst drop.
//  3 Dual write distinct: port0 x3=0x1111_1111, port1 x5=0x2222_2222 same cycle -> next cycle rd x3/x5
//    return those values, wr_conflict=0.
//  4 Conflict: port0 and port1 both write x7 (0xAAAA_AAAA / 0x5555_5555) -> x7=0x5555_5555, wr_conflict=1
//    for exactly one cycle; both writing x0 -> x0 reads 0, wr_conflict=0.
//  5 Bypass: write x9=0xDEAD_BEEF while rd_addr[0]=9 -> with REGFILE_BYPASS_EN rd_data[0]=0xDEAD_BEEF same
//    cycle; without it rd_data[0]=old value, 0xDEAD_BEEF next cycle.
//  6 Config sweep EMBEDDED=0, NUM_WR=3, NUM_RD=4: write x31 on port2 -> all 4 read ports see it; clear 31 clks.

Source files
------------

// File: rtl/multiport_regfile.sv
// multiport_regfile: parametrised RV32E/RV32I integer register file with NUM_WR write
// ports and NUM_RD combinational read ports. x0 reads as zero and ignores writes.
// When two or more write ports target the same register, the highest-index port wins.
// After reset, a hardware sequence clears x1..x(DEPTH-1) before writes are accepted.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module multiport_regfile #(
   parameter int unsigned EMBEDDED = 1,
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned NUM_RD   = 2,
   localparam int unsigned AW      = (EMBEDDED != 0) ? 4 : 5,
   localparam int unsigned DEPTH   = 1 << AW
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     ready,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*XLEN-1:0]   wr_data,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic                     wr_conflict
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_idx_q, clr_idx_d;
   logic            ready_d;
   logic            wr_conflict_d;
   logic            conflict_c;

   logic [XLEN-1:0] regs   [DEPTH];
   logic            wr_hit [DEPTH];
   logic [XLEN-1:0] wr_val [DEPTH];

   // Per-register write resolution: later (higher-index) ports override earlier ones.
   always_comb begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
         wr_hit[a] = 1'b0;
         wr_val[a] = '0;
         for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(a))) begin
               wr_hit[a] = 1'b1;
               wr_val[a] = wr_data[p*XLEN +: XLEN];
            end
         end
         if ((a == 0) || (state_q != RUN) || rst) begin
            wr_hit[a] = 1'b0;
         end
      end
   end

   // Detect two or more enabled ports sharing a non-zero address.
   always_comb begin
      conflict_c = 1'b0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         for (int unsigned j = i + 1; j < NUM_WR; j++) begin
            if (wr_en[i] && wr_en[j] &&
                (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]) &&
                (wr_addr[i*AW +: AW] != '0)) begin
               conflict_c = 1'b1;
            end
         end
      end
   end

   // Next-state logic for the clear/run sequencer and its registered outputs.
   always_comb begin
      state_d       = state_q;
      clr_idx_d     = clr_idx_q;
      ready_d       = ready;
      wr_conflict_d = 1'b0;
      if (rst) begin
         state_d   = CLEAR;
         clr_idx_d = AW'(1);
         ready_d   = 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_idx_d = clr_idx_q + AW'(1);
               if (clr_idx_q == AW'(DEPTH - 1)) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end
            end
            RUN: begin
               wr_conflict_d = conflict_c;
            end
            default: begin
               state_d = CLEAR;
            end
         endcase
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      ready       <= ready_d;
      wr_conflict <= wr_conflict_d;
   end

   // Storage: hardware clear walks one register per cycle, then normal writes.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == CLEAR)) begin
         regs[clr_idx_q] <= '0;
      end
      for (int unsigned a = 1; a < DEPTH; a++) begin
         if (wr_hit[a]) begin
            regs[a] <= wr_val[a];
         end
      end
   end

   // Read ports: zero for x0 and while clearing, optional same-cycle forwarding.
   always_comb begin
      rd_data = '0;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         if ((state_q == RUN) && (rd_addr[r*AW +: AW] != '0)) begin
            rd_data[r*XLEN +: XLEN] = regs[rd_addr[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit[rd_addr[r*AW +: AW]]) begin
               rd_data[r*XLEN +: XLEN] = wr_val[rd_addr[r*AW +: AW]];
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: default RV32E 2W/2R instance plus an RV32I 3W/4R instance.
module tb_multiport_regfile;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance: EMBEDDED=1, NUM_WR=2, NUM_RD=2
   logic        rst;
   logic        ready;
   logic [1:0]  wr_en;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic [7:0]  rd_addr;
   logic [63:0] rd_data;
   logic        wr_conflict;

   // Sweep instance: EMBEDDED=0, NUM_WR=3, NUM_RD=4
   logic         rst_b;
   logic         ready_b;
   logic [2:0]   wr_en_b;
   logic [14:0]  wr_addr_b;
   logic [95:0]  wr_data_b;
   logic [19:0]  rd_addr_b;
   logic [127:0] rd_data_b;
   logic         wr_conflict_b;

   int vectors = 0;
   int miscompares = 0;

   multiport_regfile #(.EMBEDDED(1), .XLEN(32), .NUM_WR(2), .NUM_RD(2)) dut (
      .clk(clk), .rst(rst), .ready(ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .wr_conflict(wr_conflict));

   multiport_regfile #(.EMBEDDED(0), .XLEN(32), .NUM_WR(3), .NUM_RD(4)) dut_b (
      .clk(clk), .rst(rst_b), .ready(ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
      .wr_data(wr_data_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_conflict(wr_conflict_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
   endtask

   task automatic set_wr(input int p, input int a, input logic [31:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*4 +: 4]   = 4'(a);
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_a();
      rd_addr = {4'd5, 4'd0};
      tick();
      tick();
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready got %b exp 0", ready);
      end
      vectors++;
      if (wr_conflict !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_conflict got %b exp 0", wr_conflict);
      end
      vectors++;
      if (rd_data !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_rd got %h exp 0", rd_data);
      end
      rst = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         vectors++;
         if (ready !== (k == 15)) begin
            miscompares++;
            $display("FAIL reset_ready_seq k=%0d got %b exp %b", k, ready, (k == 15));
         end
      end
      for (int a = 0; a < 16; a++) begin
         rd_addr = {4'(15 - a), 4'(a)};
         #1;
         vectors++;
         if (rd_data !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rd_all a=%0d got %h exp 0", a, rd_data);
         end
      end
   endtask

   task automatic test_clear_after_fill();
      for (int a = 1; a < 16; a++) begin
         idle_a();
         set_wr(0, a, 32'(a) * 32'h0101_0101);
         tick();
      end
      idle_a();
      rd_addr = {4'd15, 4'd4};
      #1;
      vectors++;
      if (rd_data !== {32'h0F0F_0F0F, 32'h0404_0404}) begin
         miscompares++;
         $display("FAIL fill_rd got %h exp %h", rd_data, {32'h0F0F_0F0F, 32'h0404_0404});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_wr(0, 6, 32'hFFFF_FFFF);
      set_wr(1, 6, 32'hEEEE_EEEE);
      for (int k = 1; k <= 15; k++) begin
         tick();
         vectors++;
         if (ready !== (k == 15)) begin
            miscompares++;
            $display("FAIL clear_ready k=%0d got %b exp %b", k, ready, (k == 15));
         end
         vectors++;
         if (wr_conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_conflict k=%0d got %b exp 0", k, wr_conflict);
         end
         vectors++;
         if (rd_data !== 64'h0) begin
            miscompares++;
            $display("FAIL clear_rd k=%0d got %h exp 0", k, rd_data);
         end
      end
      idle_a();
      for (int a = 1; a < 16; a++) begin
         rd_addr = {4'(a), 4'(a)};
         #1;
         vectors++;
         if (rd_data !== 64'h0) begin
            miscompares++;
            $display("FAIL clear_rd_all a=%0d got %h exp 0", a, rd_data);
         end
      end
   endtask

   task automatic test_mid_clear();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         vectors++;
         if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midclr_pre k=%0d got %b exp 0", k, ready);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         vectors++;
         if (ready !== (k == 15)) begin
            miscompares++;
            $display("FAIL midclr_ready k=%0d got %b exp %b", k, ready, (k == 15));
         end
      end
   endtask

   task automatic test_dual_write();
      logic [63:0] exp;
      idle_a();
      set_wr(0, 3, 32'h1111_1111);
      set_wr(1, 5, 32'h2222_2222);
      rd_addr = {4'd5, 4'd3};
      #1;
      exp = BYP ? {32'h2222_2222, 32'h1111_1111} : 64'h0;
      vectors++;
      if (rd_data !== exp) begin
         miscompares++;
         $display("FAIL dual_same_cycle got %h exp %h", rd_data, exp);
      end
      tick();
      idle_a();
      #1;
      vectors++;
      if (rd_data !== {32'h2222_2222, 32'h1111_1111}) begin
         miscompares++;
         $display("FAIL dual_rd got %h exp %h", rd_data, {32'h2222_2222, 32'h1111_1111});
      end
      vectors++;
      if (wr_conflict !== 1'b0) begin
         miscompares++;
         $display("FAIL dual_conflict got %b exp 0", wr_conflict);
      end
   endtask

   task automatic test_conflict();
      idle_a();
      set_wr(0, 7, 32'hAAAA_AAAA);
      set_wr(1, 7, 32'h5555_5555);
      rd_addr = {4'd7, 4'd7};
      tick();
      idle_a();
      #1;
      vectors++;
      if (wr_conflict !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_pulse got %b exp 1", wr_conflict);
      end
      vectors++;
      if (rd_data !== {32'h5555_5555, 32'h5555_5555}) begin
         miscompares++;
         $display("FAIL conflict_prio got %h exp %h", rd_data, {32'h5555_5555, 32'h5555_5555});
      end
      tick();
      vectors++;
      if (wr_conflict !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_one_cycle got %b exp 0", wr_conflict);
      end
      set_wr(0, 0, 32'h1234_5678);
      set_wr(1, 0, 32'h8765_4321);
      rd_addr = {4'd0, 4'd0};
      #1;
      vectors++;
      if (rd_data !== 64'h0) begin
         miscompares++;
         $display("FAIL x0_same_cycle got %h exp 0", rd_data);
      end
      tick();
      idle_a();
      #1;
      vectors++;
      if (wr_conflict !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_conflict got %b exp 0", wr_conflict);
      end
      vectors++;
      if (rd_data !== 64'h0) begin
         miscompares++;
         $display("FAIL x0_rd got %h exp 0", rd_data);
      end
   endtask

   task automatic test_bypass();
      logic [63:0] exp;
      idle_a();
      set_wr(1, 9, 32'h1234_5678);
      tick();
      idle_a();
      set_wr(0, 9, 32'hDEAD_BEEF);
      rd_addr = {4'd9, 4'd9};
      #1;
      exp = BYP ? {32'hDEAD_BEEF, 32'hDEAD_BEEF} : {32'h1234_5678, 32'h1234_5678};
      vectors++;
      if (rd_data !== exp) begin
         miscompares++;
         $display("FAIL bypass_same_cycle got %h exp %h", rd_data, exp);
      end
      tick();
      idle_a();
      #1;
      vectors++;
      if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
         miscompares++;
         $display("FAIL bypass_next_cycle got %h exp %h", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
      end
      set_wr(0, 10, 32'hAAAA_0000);
      set_wr(1, 10, 32'hBBBB_0000);
      rd_addr = {4'd9, 4'd10};
      #1;
      exp = BYP ? {32'hDEAD_BEEF, 32'hBBBB_0000} : {32'hDEAD_BEEF, 32'h0};
      vectors++;
      if (rd_data !== exp) begin
         miscompares++;
         $display("FAIL bypass_prio got %h exp %h", rd_data, exp);
      end
      tick();
      idle_a();
      #1;
      vectors++;
      if (rd_data !== {32'hDEAD_BEEF, 32'hBBBB_0000}) begin
         miscompares++;
         $display("FAIL bypass_prio_next got %h exp %h", rd_data, {32'hDEAD_BEEF, 32'hBBBB_0000});
      end
   endtask

   task automatic test_config_sweep();
      logic [127:0] exp;
      wr_en_b   = '0;
      wr_addr_b = '0;
      wr_data_b = '0;
      rd_addr_b = {5'd31, 5'd31, 5'd31, 5'd31};
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         tick();
         vectors++;
         if (ready_b !== (k == 31)) begin
            miscompares++;
            $display("FAIL sweep_ready k=%0d got %b exp %b", k, ready_b, (k == 31));
         end
      end
      wr_en_b   = 3'b101;
      wr_addr_b = {5'd31, 5'd0, 5'd31};
      wr_data_b = {32'hCAFE_F00D, 32'h0, 32'h0000_0001};
      #1;
      exp = BYP ? {4{32'hCAFE_F00D}} : 128'h0;
      vectors++;
      if (rd_data_b !== exp) begin
         miscompares++;
         $display("FAIL sweep_same_cycle got %h exp %h", rd_data_b, exp);
      end
      tick();
      wr_en_b = '0;
      #1;
      vectors++;
      if (rd_data_b !== {4{32'hCAFE_F00D}}) begin
         miscompares++;
         $display("FAIL sweep_rd got %h exp %h", rd_data_b, {4{32'hCAFE_F00D}});
      end
      vectors++;
      if (wr_conflict_b !== 1'b1) begin
         miscompares++;
         $display("FAIL sweep_conflict got %b exp 1", wr_conflict_b);
      end
      tick();
      vectors++;
      if (wr_conflict_b !== 1'b0) begin
         miscompares++;
         $display("FAIL sweep_conflict_clr got %b exp 0", wr_conflict_b);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      rst_b     = 1'b1;
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      rd_addr   = '0;
      wr_en_b   = '0;
      wr_addr_b = '0;
      wr_data_b = '0;
      rd_addr_b = '0;
      test_reset();
      test_clear_after_fill();
      test_mid_clear();
      test_dual_write();
      test_conflict();
      test_bypass();
      test_config_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
